// File: rtl/mvm_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mvm_engine                                                               |
// | 4x4 matrix-vector multiply accelerator fed by a one-read-per-cycle port.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mvm_engine #(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          acc_start,
  input  logic [AW-1:0] mbase,
  input  logic [AW-1:0] vbase,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic [1:0]    dic_idx,
  output logic [DW-1:0] dic_data,
  output logic [DW-1:0] hs_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] c_vec_len    = 5'd4;
  localparam logic [4:0] c_last_issue = 5'd19;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [4:0]    r_cnt;
  logic [AW-1:0] r_mbase;
  logic [AW-1:0] r_vbase;
  logic [DW-1:0] r_vec [4];
  logic [DW-1:0] r_res [4];
  logic          r_done;
  logic          r_err;
  logic          r_pend_vld;
  logic [4:0]    r_pend_k;

  logic          w_accept;
  logic          w_busy;
  logic          w_mem_re;
  logic [AW-1:0] w_addr;
  logic [3:0]    w_mat_k;
  logic [1:0]    w_row;
  logic [1:0]    w_col;
  logic [DW-1:0] w_prod;
  logic [DW-1:0] w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_busy      = 1'b1;
    w_mem_re    = 1'b0;
    w_addr      = '0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (acc_start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_mem_re = 1'b1;
        // First four issues fetch the vector, the remaining sixteen walk the matrix row-major.
        if (r_cnt < c_vec_len) begin
          w_addr = r_vbase + AW'(r_cnt);
        end else begin
          w_addr = r_mbase + AW'(r_cnt - c_vec_len);
        end
        if (r_cnt == c_last_issue) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: w_state_nxt = DONE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_mbase <= '0;
      r_vbase <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_mbase <= mbase;
        r_vbase <= vbase;
        r_done  <= 1'b0;
        r_err   <= 1'b0;
      end else if (acc_start && w_busy) begin
        r_err <= 1'b1;
      end
      if (r_state == RUN) begin
        r_cnt <= (r_cnt == c_last_issue) ? 5'd0 : r_cnt + 5'd1;
      end
      if (r_state == DONE) begin
        r_done <= 1'b1;
      end
    end
  end

  // Read data returns one cycle after issue, so remember what was asked for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_vld <= 1'b0;
      r_pend_k   <= '0;
    end else begin
      r_pend_vld <= w_mem_re;
      r_pend_k   <= r_cnt;
    end
  end

  assign w_mat_k = 4'(r_pend_k - c_vec_len);
  assign w_row   = w_mat_k[3:2];
  assign w_col   = w_mat_k[1:0];
  assign w_prod  = mem_rdata * r_vec[w_col];
  assign w_sum   = r_res[w_row] + w_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_vec[i] <= '0;
        r_res[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        for (int i = 0; i < 4; i++) begin
          r_res[i] <= '0;
        end
      end else if (r_pend_vld) begin
        if (r_pend_k < c_vec_len) begin
          r_vec[r_pend_k[1:0]] <= mem_rdata;
        end else begin
          r_res[w_row] <= w_sum;
        end
      end
    end
  end

  assign mem_re   = w_mem_re;
  assign mem_addr = w_addr;
  assign busy     = w_busy;
  assign hs_data  = {{(DW-3){1'b0}}, r_err, r_done, w_busy};
  assign dic_data = r_res[dic_idx];

endmodule
`default_nettype wire

// File: tb/tb_mvm_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mvm_engine                                                            |
// | Directed and randomized checks of mvm_engine against a dot-product model.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mvm_engine;

  logic        clk;
  logic        rst_n;
  logic        acc_start;
  logic [15:0] mbase;
  logic [15:0] vbase;
  logic        mem_re;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [1:0]  dic_idx;
  logic [15:0] dic_data;
  logic [15:0] hs_data;
  logic        busy;

  logic [15:0] mem [65536];
  logic [15:0] addr_q [$];
  logic [15:0] exp_res [4];
  int          vectors;
  int          miscompares;

  mvm_engine #(.DW(16), .AW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_start (acc_start),
    .mbase     (mbase),
    .vbase     (vbase),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .dic_idx   (dic_idx),
    .dic_data  (dic_data),
    .hs_data   (hs_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory; junk on idle cycles exposes mistimed captures.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= 16'($urandom);
  end

  always @(negedge clk) begin
    if (mem_re === 1'b1) addr_q.push_back(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_res(input logic [15:0] mb, input logic [15:0] vb, input int r);
    int unsigned acc;
    logic [15:0] ma;
    logic [15:0] va;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      ma  = mb + 16'(4 * r + c);
      va  = vb + 16'(c);
      acc = acc + mem[ma] * mem[va];
    end
    return acc[15:0];
  endfunction

  task automatic set_model(input logic [15:0] mb, input logic [15:0] vb);
    for (int r = 0; r < 4; r++) exp_res[r] = model_res(mb, vb, r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] mb, input logic [15:0] vb);
    addr_q.delete();
    acc_start = 1'b1;
    mbase     = mb;
    vbase     = vb;
    tick();
    acc_start = 1'b0;
    mbase     = 16'($urandom);
    vbase     = 16'($urandom);
  endtask

  task automatic finish_job(input string tag, input int elapsed, input logic [15:0] mb,
                            input logic [15:0] vb, input logic [15:0] exp_hs);
    int cyc;
    int bad;
    logic [15:0] ea;
    cyc = elapsed;
    while (busy === 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk($sformatf("%s_busy_cycles", tag), cyc, 22);
    chk($sformatf("%s_addr_count", tag), addr_q.size(), 20);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      ea = (i < 4) ? vb + 16'(i) : mb + 16'(i - 4);
      if (i < addr_q.size() && addr_q[i] !== ea) bad++;
    end
    chk($sformatf("%s_addr_order_errs", tag), bad, 0);
    for (int i = 0; i < 4; i++) begin
      dic_idx = 2'(i);
      #1;
      chk($sformatf("%s_res%0d", tag, i), dic_data, exp_res[i]);
    end
    chk($sformatf("%s_hs", tag), hs_data, exp_hs);
  endtask

  initial begin
    logic [15:0] mb;
    logic [15:0] vb;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    acc_start   = 1'b0;
    mbase       = '0;
    vbase       = '0;
    dic_idx     = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

    #3;
    chk("rst_busy", busy, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_hs", hs_data, 0);
    chk("rst_dic", dic_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Identity matrix times {1,2,3,4}
    for (int i = 0; i < 16; i++) mem[16'h0010 + i] = (i % 5 == 0) ? 16'd1 : 16'd0;
    for (int i = 0; i < 4; i++)  mem[16'h0040 + i] = 16'(i + 1);
    exp_res = '{16'd1, 16'd2, 16'd3, 16'd4};
    start_job(16'h0010, 16'h0040);
    finish_job("ident", 0, 16'h0010, 16'h0040, 16'h0002);
    chk("idle_mem_re", mem_re, 0);
    chk("idle_mem_addr", mem_addr, 0);

    // Wrapping products, launched on the first IDLE cycle after DONE
    for (int i = 0; i < 4; i++)  mem[16'h0200 + i] = 16'h0100;
    for (int i = 0; i < 16; i++) mem[16'h0300 + i] = (i < 4) ? 16'h0100 : 16'h0003;
    exp_res = '{16'h0000, 16'h0C00, 16'h0C00, 16'h0C00};
    start_job(16'h0300, 16'h0200);
    chk("b2b_accept_hs", hs_data, 16'h0001);
    finish_job("wrap", 0, 16'h0300, 16'h0200, 16'h0002);

    // Matrix base wrapping past the top of the address space
    set_model(16'hFFFE, 16'h1234);
    start_job(16'hFFFE, 16'h1234);
    finish_job("addr_wrap", 0, 16'hFFFE, 16'h1234, 16'h0002);

    // Start strobe while busy must be ignored and flagged
    set_model(16'h0500, 16'h0600);
    start_job(16'h0500, 16'h0600);
    repeat (5) tick();
    acc_start = 1'b1;
    mbase     = 16'h7000;
    vbase     = 16'h7100;
    tick();
    acc_start = 1'b0;
    chk("busy_start_hs_during", hs_data, 16'h0005);
    finish_job("busy_start", 6, 16'h0500, 16'h0600, 16'h0006);
    set_model(16'h0A00, 16'h0B00);
    start_job(16'h0A00, 16'h0B00);
    chk("err_clear_hs", hs_data, 16'h0001);
    finish_job("err_clear", 0, 16'h0A00, 16'h0B00, 16'h0002);

    // Asynchronous reset in the middle of a job
    start_job(16'h0800, 16'h0900);
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_re", mem_re, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_dic", dic_data, 0);
    chk("midrst_hs", hs_data, 0);
    set_model(16'h0C00, 16'h0D00);
    @(negedge clk);
    rst_n     = 1'b1;
    addr_q.delete();
    acc_start = 1'b1;
    mbase     = 16'h0C00;
    vbase     = 16'h0D00;
    tick();
    acc_start = 1'b0;
    chk("postrst_accept", busy, 1);
    finish_job("postrst", 0, 16'h0C00, 16'h0D00, 16'h0002);

    // Randomized jobs against the dot-product model
    for (int j = 0; j < 6; j++) begin
      mb = 16'($urandom);
      vb = 16'($urandom);
      set_model(mb, vb);
      start_job(mb, vb);
      finish_job($sformatf("rand%0d", j), 0, mb, vb, 16'h0002);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mvm_engine.md
MVM_ENGINE -- requirements
Module: mvm_engine

Interface
REQ-001 Parameter DW, default 16: data width of memory words, vector elements and results.
REQ-002 Parameter AW, default 16: data-memory address width.
REQ-003 The port list SHALL be (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- acc_start  in  1  one-cycle MVM launch strobe, driven from the decoder's ACC output.
- mbase  in  AW  matrix base address (MVM rd operand value).
- vbase  in  AW  vector base address (MVM rs operand value).
- mem_re  out  1  data-memory read enable (dedicated read port).
- mem_addr  out  AW  data-memory read address.
- mem_rdata  in  DW  read data, valid the cycle after mem_re.
- dic_idx  in  2  result index for the DIC writeback.
- dic_data  out  DW  result[dic_idx], combinational (Mem_src 110 source).
- hs_data  out  DW  status word (Mem_src 111 source).
- busy  out  1  job in progress.

Function
REQ-004 States SHALL be IDLE, RUN, DRAIN and DONE, with a 5-bit issue counter cnt.
REQ-005 IDLE: when acc_start=1, the block SHALL latch mbase and vbase, clear res[0..3] and done, set cnt=0, and enter RUN.
REQ-006 RUN: mem_re SHALL be 1 on every cycle; cnt SHALL increment on every edge; after the cnt=19 cycle the state SHALL become DRAIN.
REQ-007 Addressing: for cnt 0..3, mem_addr SHALL be vbase+cnt; for cnt 4..19, mem_addr SHALL be mbase+(cnt-4). All sums are modulo 2^AW.
REQ-008 The element issued at cnt=k SHALL be captured at the edge ending the following cycle (the RUN cycle k+1, or DRAIN for k=19).
REQ-009 Capture for k 0..3: vec[k] SHALL be loaded with mem_rdata.
REQ-010 Capture for k 4..19: with row=(k-4)>>2 and col=(k-4)&3, res[row] SHALL update to res[row] + mem_rdata*vec[col]. The product and the sum are each truncated to the low DW bits (unsigned, wrapping).
REQ-011 DRAIN SHALL last one cycle with mem_re=0, then go to DONE.
REQ-012 DONE SHALL last one cycle: set the sticky flag done=1, then return to IDLE.
REQ-013 busy SHALL be 1 in RUN, DRAIN and DONE (22 cycles per job) and 0 in IDLE.
REQ-014 acc_start seen while busy=1 SHALL be ignored, with no change to the job, and SHALL set the sticky flag err=1.
REQ-015 err SHALL be cleared by the next accepted start.
REQ-016 hs_data SHALL be {DW-3 zeros, err, done, busy}.
REQ-017 dic_data SHALL reflect the current res[dic_idx] in every state; partial sums are visible during RUN.
REQ-018 mem_re SHALL be 0 and mem_addr SHALL hold 0 outside RUN.
REQ-019 An acc_start coincident with DONE SHALL be treated as busy (REQ-014); it is accepted only in IDLE.

Reset
REQ-020 Asserting rst_n=0 SHALL asynchronously force all of the following, with no clock needed: state=IDLE, cnt=0, vec[0..3]=0, res[0..3]=0, done=0, err=0, latched bases=0.
REQ-021 Outputs during reset SHALL be mem_re=0, mem_addr=0, busy=0, hs_data=0, dic_data=0.
REQ-022 Reset mid-job SHALL discard in-flight read data. After release the block SHALL be in IDLE and accept acc_start on the first clock edge.

Verification
REQ-023 Identity: memory[0x0010..0x001F]=4x4 identity, memory[0x0040..0x0043]={1,2,3,4}, start with mbase=0x0010, vbase=0x0040 -> busy for 22 cycles, 20 reads in exact address order, res={1,2,3,4}, hs_data=0x0002.
REQ-024 Wrap arithmetic: vector all 0x0100, matrix row 0 all 0x0100, other rows all 0x0003, vector[1]=0x0100 -> res[0]=0x0000 (product truncation); for rows 1..3, with all vector entries 0x0100, res=0x0C00.
REQ-025 Address wrap: mbase=0xFFFE -> matrix reads issued at 0xFFFE, 0xFFFF, 0x0000 ... 0x000D.
REQ-026 Start while busy: second acc_start at RUN cycle 5 with different bases -> addresses unchanged, hs_data=0x0005 during job and 0x0006 after. A following IDLE start -> err cleared.
REQ-027 Reset mid-job: rst_n low at RUN cycle 10 -> immediately busy=0, mem_re=0, dic_data=0. New job after release completes with correct results.
REQ-028 Back-to-back: acc_start on the first IDLE cycle after DONE -> accepted; done reads 0 during the new job.
